rle_decode: RTL and testbench
=============================

Name: rle_decode

Overview:
- Consumes {count, value} run-length tokens and expands each run back into a one-pixel-per-cycle stream with valid/ready handshakes.
- Sits directly downstream of the RLE encoder on the FPGA side.
- Used for on-chip loopback checking and for feeding decoded pixel masks to later vision stages.
- Tracks pixel position within a frame and flags the last pixel of every frame.

Parameters:
- data_width_p, 2, width of one pixel value.
- bus_width_p, 8, width of one packed token.
- count_width_p, bus_width_p - data_width_p, width of the run-length field.
- frame_pixels_p, 76800, pixels per frame; must be ≥1.
- pix_idx_width_p, $clog2(frame_pixels_p), width of the frame pixel counter.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  reset, asynchronous and active-high.
- rle_value_i  in  data_width_p  pixel value of the incoming run.
- rle_count_i  in  count_width_p  run length of the incoming token; 0 means an empty run.
- valid_i  in  1  token valid.
- ready_o  out  1  token accept.
- data_o  out  data_width_p  decoded pixel.
- last_o  out  1  data_o is pixel frame_pixels_p-1 of the current frame.
- valid_o  out  1  pixel valid.
- ready_i  in  1  downstream accept.

Behaviour:
- Fire definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Reset (async assert, sync-release assumed upstream):
  - state=IDLE, value_r=0, remain_r=0, pix_idx_r=0.
  - Outputs: valid_o=0, data_o=0, last_o=0, ready_o=0 while reset_i is high.
- FSM, two states:
  - IDLE: ready_o=1, valid_o=0. On in_fire with rle_count_i≠0: value_r←rle_value_i, remain_r←rle_count_i, go to EMIT. On in_fire with rle_count_i=0: token consumed and dropped, stay in IDLE.
  - EMIT: valid_o=1, data_o=value_r. On out_fire, remain_r decrements.
    - When remain_r=1 and out_fire occurs, the run ends. ready_o=1 in that cycle only, so the next token is accepted concurrently with zero bubble.
    - If that accepted token has a nonzero count, load it and stay in EMIT.
    - Otherwise (zero count, or no token presented) go to IDLE.
  - ready_o=0 in EMIT whenever remain_r>1 or ready_i=0.
- ready_o depends combinationally on ready_i in the last-pixel cycle. This is the only combinational path through the block.
- Latency: the first pixel of a token appears on valid_o the cycle after the token's in_fire. Steady throughput is one pixel per cycle.
- Run length: a token with count N produces exactly N pixels. A maximal count (all ones) produces 2^count_width_p - 1 pixels with no overflow.
- Output stability: data_o, last_o and valid_o are registered/state-derived. They hold stable while valid_o=1 and ready_i=0.
- Frame position:
  - pix_idx_r increments on every out_fire and wraps to 0 after frame_pixels_p-1.
  - last_o = valid_o & (pix_idx_r == frame_pixels_p-1).
  - A run that crosses a frame boundary is not truncated. last_o marks the boundary pixel and the remaining pixels continue into the next frame at index 0.
- Backpressure: ready_i low at any point in EMIT freezes remain_r, pix_idx_r and the outputs.
- Reset mid-run: the current run is discarded and pix_idx_r returns to 0.

Decomposition:
- Shared package rle_pkg holds:
  - default data_width_p, bus_width_p and count width constants;
  - token struct typedef {count, value};
  - state enum {IDLE, EMIT}.
- The encoder uses the same package.
- One sub-module is natural: frame_counter, a parameterised wrapping counter with enable and a terminal-count output. It supplies pix_idx_r and the last_o term.

Test Plan:
- Single run, data_width_p=2, count_width_p=6: token {count=3, value=2}, ready_i=1 → data_o=2 for exactly 3 consecutive cycles starting the cycle after in_fire; then valid_o=0.
- Back-to-back runs: tokens {2,1}, {1,3}, {4,0} held valid → pixel stream 1,1,3,0,0,0,0 with no bubble. ready_o high only in each last-pixel cycle.
- Zero-count and max-count tokens: {0,3} is consumed with no output. {63,1} yields exactly 63 pixels of value 1.
- Backpressure: token {5,2} with ready_i toggling 1,0,0,1,… → exactly 5 fires. data_o is stable while stalled. ready_o stays 0 until the 5th pixel fires.
- Frame boundary, frame_pixels_p=8: tokens {6,1}, {5,2} → last_o on the 8th pixel (value 2, pix_idx 7). The next 3 pixels of value 2 carry indices 0..2 of the new frame.
- Async reset mid-run during token {10,3} after 4 pixels → valid_o drops immediately with no clock edge. After release, token {2,0} gives 2 pixels at indices 0,1.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair: default widths,
// the packed {count, value} token and the decoder state encoding.
package rle_pkg;

    localparam int DATA_WIDTH_DEF  = 2;
    localparam int BUS_WIDTH_DEF   = 8;
    localparam int COUNT_WIDTH_DEF = BUS_WIDTH_DEF - DATA_WIDTH_DEF;

    typedef struct packed {
        logic [COUNT_WIDTH_DEF-1:0] count;
        logic [DATA_WIDTH_DEF-1:0]  value;
    } rle_token_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } rle_state_e;

    // Counter width that stays legal for a single-pixel frame.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rle_decode_if.sv
// Token-in / pixel-out handshake bundle for rle_decode.
interface rle_decode_if #(
    parameter int data_width_p  = rle_pkg::DATA_WIDTH_DEF,
    parameter int count_width_p = rle_pkg::COUNT_WIDTH_DEF
);

    logic [data_width_p-1:0]  rle_value_i;
    logic [count_width_p-1:0] rle_count_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [data_width_p-1:0]  data_o;
    logic                     last_o;
    logic                     valid_o;
    logic                     ready_i;

    modport slave (
        input  rle_value_i,
        input  rle_count_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output last_o,
        output valid_o
    );

    modport master (
        output rle_value_i,
        output rle_count_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  last_o,
        input  valid_o
    );

endinterface

// File: rtl/rle_decode_frame_counter.sv
// Wrapping modulo-max_p counter with enable; tc_o flags the final count.
module frame_counter #(
    parameter int max_p   = 8,
    parameter int width_p = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [width_p-1:0] LAST_COUNT = width_p'(max_p - 1);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST_COUNT) ? '0 : count_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/rle_decode.sv
// Expands {count, value} run-length tokens into a one-pixel-per-cycle stream
// and marks the last pixel of each frame.
module rle_decode
    import rle_pkg::*;
#(
    parameter int data_width_p    = DATA_WIDTH_DEF,
    parameter int bus_width_p     = BUS_WIDTH_DEF,
    parameter int count_width_p   = bus_width_p - data_width_p,
    parameter int frame_pixels_p  = 76800,
    parameter int pix_idx_width_p = idx_width(frame_pixels_p)
) (
    input  logic     clk_i,
    input  logic     reset_i,
    rle_decode_if.slave io
);

    rle_state_e               state_q;
    rle_state_e               state_d;
    logic [data_width_p-1:0]  value_q;
    logic [data_width_p-1:0]  value_d;
    logic [count_width_p-1:0] remain_q;
    logic [count_width_p-1:0] remain_d;
    logic                     ready_int;
    logic                     tok_nonzero;
    logic                     out_fire;
    logic                     frame_tc;

    assign tok_nonzero = (io.rle_count_i != '0);

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        remain_d  = remain_q;
        ready_int = 1'b0;
        case (state_q)
            IDLE: begin
                ready_int = 1'b1;
                if (io.valid_i && tok_nonzero) begin
                    value_d  = io.rle_value_i;
                    remain_d = io.rle_count_i;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (io.ready_i) begin
                    if (remain_q == count_width_p'(1)) begin
                        // Last pixel leaves this cycle: take the next token now
                        // so consecutive runs join without a bubble.
                        ready_int = 1'b1;
                        if (io.valid_i && tok_nonzero) begin
                            value_d  = io.rle_value_i;
                            remain_d = io.rle_count_i;
                        end else begin
                            remain_d = '0;
                            state_d  = IDLE;
                        end
                    end else begin
                        remain_d = remain_q - count_width_p'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            value_q  <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            remain_q <= remain_d;
        end
    end

    assign out_fire = io.valid_o & io.ready_i;

    frame_counter #(
        .max_p   (frame_pixels_p),
        .width_p (pix_idx_width_p)
    ) u_frame_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (out_fire),
        .tc_o    (frame_tc)
    );

    assign io.valid_o = (state_q == EMIT);
    assign io.data_o  = value_q;
    assign io.last_o  = io.valid_o & frame_tc;
    // Held low for the whole reset, including the IDLE state it forces.
    assign io.ready_o = ready_int & ~reset_i;

endmodule

// File: tb/tb_rle_decode.sv
// Randomized bench for rle_decode: tokens are expanded into an expected pixel
// queue and every output cycle is compared against it.
module tb_rle_decode;
    import rle_pkg::*;

    localparam int FRAME = 8;

    typedef struct {
        logic [1:0] value;
        bit         run_end;
    } pix_t;

    logic clk = 1'b0;
    logic reset_i;
    bit   stall_mode = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pix    = 0;
    int   model_idx = 0;
    int   q_len;
    bit   exp_ready;
    pix_t exp_q[$];

    rle_decode_if #(.data_width_p(2), .count_width_p(6)) bus ();

    rle_decode #(
        .data_width_p   (2),
        .bus_width_p    (8),
        .frame_pixels_p (FRAME)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .io      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.ready_i = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Reference model: expected pixels are taken from the queue head, the
    // frame index advances on every accepted pixel.
    always @(negedge clk) begin
        if (reset_i === 1'b0) begin
            q_len = exp_q.size();
            check("valid_o", bus.valid_o, q_len != 0);
            if (q_len == 0) begin
                exp_ready = 1'b1;
            end else begin
                exp_ready = exp_q[0].run_end && bus.ready_i;
                check("data_o", bus.data_o, exp_q[0].value);
                check("last_o", bus.last_o, model_idx == FRAME - 1);
            end
            check("ready_o", bus.ready_o, exp_ready);
            if (q_len != 0 && bus.ready_i) begin
                void'(exp_q.pop_front());
                model_idx = (model_idx + 1) % FRAME;
                n_pix++;
            end
            if (bus.valid_i && exp_ready) begin
                for (int k = 0; k < int'(bus.rle_count_i); k++) begin
                    exp_q.push_back('{value: bus.rle_value_i, run_end: (k == int'(bus.rle_count_i) - 1)});
                end
            end
        end
    end

    task automatic send_token(input int cnt, input int val);
        rle_token_t tok;
        int waited;
        waited = 0;
        tok.count = 6'(cnt);
        tok.value = 2'(val);
        bus.rle_count_i = tok.count;
        bus.rle_value_i = tok.value;
        bus.valid_i     = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.ready_o) break;
            waited++;
            if (waited > 500) begin
                check("token_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_o"}, bus.valid_o, 1'b0);
        check({tag, "_ready_o"}, bus.ready_o, 1'b0);
        check({tag, "_data_o"},  bus.data_o,  2'd0);
        check({tag, "_last_o"},  bus.last_o,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int waited;
        reset_i         = 1'b1;
        bus.valid_i     = 1'b0;
        bus.rle_count_i = '0;
        bus.rle_value_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #3;
        reset_i = 1'b0;

        // Single run, then a frame-crossing pair of runs.
        send_token(3, 2);
        wait_idle();
        model_idx = model_idx; // frame position continues across tests
        send_token(6, 1);
        send_token(5, 2);
        wait_idle();

        // Back-to-back runs held valid.
        send_token(2, 1);
        send_token(1, 3);
        send_token(4, 0);
        wait_idle();

        // Zero-count and maximal-count tokens.
        send_token(0, 3);
        send_token(63, 1);
        send_token(0, 2);
        wait_idle();

        // Backpressure on a mid-length run.
        stall_mode = 1'b1;
        send_token(5, 2);
        wait_idle();

        // Randomized tokens with random backpressure and idle gaps.
        for (int t = 0; t < 60; t++) begin
            int cnt;
            cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
            send_token(cnt, $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        stall_mode = 1'b0;

        // Asynchronous reset in the middle of a run.
        base = n_pix;
        send_token(10, 3);
        waited = 0;
        while (n_pix < base + 4 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("midrun_pixels_seen", n_pix >= base + 4, 1'b1);
        @(posedge clk);
        #3;
        reset_i = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        model_idx = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_i = 1'b0;
        base = n_pix;
        send_token(2, 0);
        wait_idle();
        check("post_reset_pixels", n_pix - base, 32'd2);
        check("post_reset_frame_idx", model_idx, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
